control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL provide clk  input  1  system clock, all state changes on rising edge.
REQ-002 SHALL provide clr  input  1  one clock; reset is asynchronous and active-high (clr), forces state RST.
REQ-003 SHALL provide ir  input  32  instruction register contents; opcode = ir[31:27].
REQ-004 SHALL provide con  input  1  branch-condition flag from the CON flip-flop.
REQ-005 SHALL provide src_ctl  output  6  one-hot bus source {PCout, Zlowout, Zhighout, MDRout, Cout, Rout}, bit 5..0.
REQ-006 SHALL provide ld_ctl  output  8  load enables {MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, Rin, CONIn}, bit 7..0.
REQ-007 SHALL provide reg_sel  output  4  {Gra, Grb, Grc, BAout}, bit 3..0.
REQ-008 SHALL provide alu_op  output  4  one-hot {add, subtract, andSignal, orSignal}, bit 3..0.
REQ-009 SHALL provide IncPC, read, write  output  1 each  PC increment, memory read, memory write.
REQ-010 SHALL provide run  output  1  high while executing, low in RST and HALT.
REQ-011 SHALL provide state  output  5  current state encoding, for debug.

Function
REQ-012 All outputs SHALL be Moore-decoded from state only; con sampled only in BR3.
REQ-013 src_ctl SHALL have at most one bit set in every state.
REQ-014 Fetch: F0 = PCout, MARIn, IncPC, ZIn; F1 = Zlowout, PCIn, read; F2 = read, MDRIn; F3 = MDRout, IRIn; F3 -> DEC.
REQ-015 DEC SHALL drive no controls, take one cycle, branch on ir[31:27] (IR valid after F3 edge).
REQ-016 Opcodes: 00000 ld, 00001 ldi, 00010 st, 00011 add, 00100 sub, 00101 and, 00110 or, 10010 br, 11010 nop, 11011 halt; any other opcode SHALL execute as nop.
REQ-017 ALU ops (add/sub/and/or): A0 = Grb, Rout, YIn; A1 = Grc, Rout, matching alu_op bit, ZIn; A2 = Zlowout, Gra, Rin; A2 -> F0.
REQ-018 Address calc (ld/ldi/st): E0 = Grb, BAout, Rout, YIn; E1 = Cout, add, ZIn; ldi E2 = Zlowout, Gra, Rin -> F0.
REQ-019 ld after E1: L2 = Zlowout, MARIn; L3 = read; L4 = read, MDRIn; L5 = MDRout, Gra, Rin -> F0.
REQ-020 st after E1: S2 = Zlowout, MARIn; S3 = Gra, Rout, MDRIn (read=0, MDR loads bus); S4 = write -> F0.
REQ-021 br: B0 = Gra, Rout, CONIn; B1 = PCout, YIn; B2 = Cout, add, ZIn; BR3 = Zlowout, PCIn if con=1, else no controls; -> F0.
REQ-022 nop: DEC -> F0 directly; halt: DEC -> HALT, HALT self-loops with all controls 0 and run=0 until clr.
REQ-023 Instruction cycle counts SHALL be: alu 8, ldi 8, ld 11, st 10, br 9, nop 5 (F0..DEC inclusive).
REQ-024 read and write SHALL never be high in the same state; write only in S4.
REQ-025 ir changes outside F3/DEC SHALL NOT alter the sequence in progress (opcode latched internally at DEC).
REQ-026 IncPC SHALL be asserted only in F0; PCIn only in F1 and BR3.

Reset
REQ-027 While clr=1: state=RST, src_ctl=0, ld_ctl=0, reg_sel=0, alu_op=0, IncPC=0, read=0, write=0, run=0, independent of clk.
REQ-028 clr asserted mid-instruction SHALL abort immediately, no partial control asserted after assertion.
REQ-029 First rising clk with clr=0: RST -> F0, run=1; F0 controls visible in that cycle.
REQ-030 Internal latched opcode SHALL reset to nop encoding 11010.

Verification
REQ-031 Reset: clr pulse mid-ld at L3 -> outputs all 0 same cycle, run=0; release -> F0 next edge, src_ctl=100000, ld_ctl=10000100, IncPC=1.
REQ-032 add: ir=0x18000000|ra/rb/rc -> 8-cycle trace F0..A2, A1 alu_op=1000, A2 ld_ctl=00000010, reg_sel=1000.
REQ-033 ld: opcode 00000 -> 11 cycles; read high in F1,F2,L3,L4 only; MDRIn in F2,L4; L5 src_ctl=000100.
REQ-034 st: opcode 00010 -> write=1 exactly one cycle (S4), read=0 throughout execute; 10 cycles total.
REQ-035 br: opcode 10010 with con=1 -> BR3 ld_ctl=01000000; repeat with con=0 -> BR3 ld_ctl=00000000; both return to F0.
REQ-036 halt/illegal: opcode 11011 -> HALT, run=0 held 20 cycles, only clr exits; opcode 11111 -> behaves as nop, 5 cycles.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch/decode/execute sequencer for the single-bus datapath.
// Controls are decoded from the current state; the opcode is latched at DEC.
module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con,
  output logic [5:0]  src_ctl,
  output logic [7:0]  ld_ctl,
  output logic [3:0]  reg_sel,
  output logic [3:0]  alu_op,
  output logic        IncPC,
  output logic        read,
  output logic        write,
  output logic        run,
  output logic [4:0]  state
);

  typedef enum logic [4:0] {
    S_RST = 5'd0,  S_F0  = 5'd1,  S_F1  = 5'd2,  S_F2  = 5'd3,  S_F3  = 5'd4,
    S_DEC = 5'd5,  S_A0  = 5'd6,  S_A1  = 5'd7,  S_A2  = 5'd8,  S_E0  = 5'd9,
    S_E1  = 5'd10, S_E2  = 5'd11, S_L2  = 5'd12, S_L3  = 5'd13, S_L4  = 5'd14,
    S_L5  = 5'd15, S_S2  = 5'd16, S_S3  = 5'd17, S_S4  = 5'd18, S_B0  = 5'd19,
    S_B1  = 5'd20, S_B2  = 5'd21, S_BR3 = 5'd22, S_HALT = 5'd23
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic       ir_unused;

  assign ir_unused = ^ir[26:0];
  assign state     = state_q;

  // State and latched opcode registers; clr forces RST immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_RST;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic; the opcode is captured in DEC so later ir changes are ignored.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_RST: state_d = S_F0;
      S_F0:  state_d = S_F1;
      S_F1:  state_d = S_F2;
      S_F2:  state_d = S_F3;
      S_F3:  state_d = S_DEC;
      S_DEC: begin
        op_d = ir[31:27];
        case (ir[31:27])
          OP_LD, OP_LDI, OP_ST:           state_d = S_E0;
          OP_ADD, OP_SUB, OP_AND, OP_OR:  state_d = S_A0;
          OP_BR:                          state_d = S_B0;
          OP_HALT:                        state_d = S_HALT;
          default:                        state_d = S_F0;
        endcase
      end
      S_A0:  state_d = S_A1;
      S_A1:  state_d = S_A2;
      S_A2:  state_d = S_F0;
      S_E0:  state_d = S_E1;
      S_E1: begin
        case (op_q)
          OP_LDI:  state_d = S_E2;
          OP_LD:   state_d = S_L2;
          default: state_d = S_S2;
        endcase
      end
      S_E2:  state_d = S_F0;
      S_L2:  state_d = S_L3;
      S_L3:  state_d = S_L4;
      S_L4:  state_d = S_L5;
      S_L5:  state_d = S_F0;
      S_S2:  state_d = S_S3;
      S_S3:  state_d = S_S4;
      S_S4:  state_d = S_F0;
      S_B0:  state_d = S_B1;
      S_B1:  state_d = S_B2;
      S_B2:  state_d = S_BR3;
      S_BR3: state_d = S_F0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Control decode. src bits {PC,Zlo,Zhi,MDR,C,R}; ld bits {MAR,PC,MDR,IR,Y,Z,R,CON}.
  always_comb begin
    src_ctl = 6'b000000;
    ld_ctl  = 8'b00000000;
    reg_sel = 4'b0000;
    alu_op  = 4'b0000;
    IncPC   = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    run     = 1'b1;
    case (state_q)
      S_RST, S_HALT: run = 1'b0;
      S_F0:  begin src_ctl = 6'b100000; ld_ctl = 8'b10000100; IncPC = 1'b1; end
      S_F1:  begin src_ctl = 6'b010000; ld_ctl = 8'b01000000; read = 1'b1; end
      S_F2:  begin ld_ctl = 8'b00100000; read = 1'b1; end
      S_F3:  begin src_ctl = 6'b000100; ld_ctl = 8'b00010000; end
      S_A0:  begin src_ctl = 6'b000001; ld_ctl = 8'b00001000; reg_sel = 4'b0100; end
      S_A1: begin
        src_ctl = 6'b000001;
        ld_ctl  = 8'b00000100;
        reg_sel = 4'b0010;
        case (op_q)
          OP_ADD:  alu_op = 4'b1000;
          OP_SUB:  alu_op = 4'b0100;
          OP_AND:  alu_op = 4'b0010;
          OP_OR:   alu_op = 4'b0001;
          default: alu_op = 4'b0000;
        endcase
      end
      S_A2, S_E2, S_L5: begin
        src_ctl = (state_q == S_L5) ? 6'b000100 : 6'b010000;
        ld_ctl  = 8'b00000010;
        reg_sel = 4'b1000;
      end
      S_E0:  begin src_ctl = 6'b000001; ld_ctl = 8'b00001000; reg_sel = 4'b0101; end
      S_E1, S_B2: begin src_ctl = 6'b000010; ld_ctl = 8'b00000100; alu_op = 4'b1000; end
      S_L2, S_S2: begin src_ctl = 6'b010000; ld_ctl = 8'b10000000; end
      S_L3:  read = 1'b1;
      S_L4:  begin ld_ctl = 8'b00100000; read = 1'b1; end
      S_S3:  begin src_ctl = 6'b000001; ld_ctl = 8'b00100000; reg_sel = 4'b1000; end
      S_S4:  write = 1'b1;
      S_B0:  begin src_ctl = 6'b000001; ld_ctl = 8'b00000001; reg_sel = 4'b1000; end
      S_B1:  begin src_ctl = 6'b100000; ld_ctl = 8'b00001000; end
      S_BR3: begin
        // Branch target is committed only when the condition holds.
        if (con) begin
          src_ctl = 6'b010000;
          ld_ctl  = 8'b01000000;
        end else begin
          src_ctl = 6'b000000;
          ld_ctl  = 8'b00000000;
        end
      end
      default: begin
        src_ctl = 6'b000000;
        ld_ctl  = 8'b00000000;
      end
    endcase
  end

endmodule
